// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve point datapaths.
package ecc_pkg;

  // Default field width, shared by point_double, point_add and jacobian_to_affine.
  localparam int ECC_LEN = 256;

  // Controller states of jacobian_to_affine.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXP_SQR = 3'd1,
    EXP_MUL = 3'd2,
    Z2      = 3'd3,
    Z3      = 3'd4,
    OUTX    = 3'd5,
    OUTY    = 3'd6,
    DONE    = 3'd7
  } j2a_state_t;

endpackage

// File: rtl/jacobian_to_affine_if.sv
// Point-in / point-out bus of jacobian_to_affine.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The sender holds its data stable while valid is high and ready is
// low; the receiver may raise or drop ready at will. The input side carries the
// field constants together with every point.
interface jacobian_to_affine_if #(
  parameter int LEN = 256
);
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] p;
  logic [LEN-1:0] p_prime;
  logic [LEN-1:0] r2_mod_p;
  logic [LEN-1:0] px;
  logic [LEN-1:0] py;
  logic [LEN-1:0] pz;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] ax;
  logic [LEN-1:0] ay;
  logic           inf;

  modport master (
    output in_valid, p, p_prime, r2_mod_p, px, py, pz, out_ready,
    input  in_ready, out_valid, ax, ay, inf
  );

  modport slave (
    input  in_valid, p, p_prime, r2_mod_p, px, py, pz, out_ready,
    output in_ready, out_valid, ax, ay, inf
  );
endinterface

// File: rtl/jacobian_to_affine_inv.sv
// Fermat inversion z^(p-2) mod p, left-to-right square-and-multiply. Every bit
// costs one square and one (possibly discarded) multiply, so a run is exactly
// 2*LEN cycles. The multiplier is shared: when ext_sel is high the caller's
// operands are routed to it and the exponent loop must be idle.
module mod_inv_fermat import ecc_pkg::*; #(
  parameter int LEN = ECC_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] z,
  input  logic [LEN-1:0] e,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] p_prime,
  input  logic [LEN-1:0] r2_mod_p,
  input  logic           ext_sel,
  input  logic [LEN-1:0] ext_a,
  input  logic [LEN-1:0] ext_b,
  output logic [LEN-1:0] acc,
  output logic [LEN-1:0] mul_y,
  output logic           done
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [IW-1:0]  idx;
  logic           busy;
  logic           sqr;
  logic [LEN-1:0] mul_a;
  logic [LEN-1:0] mul_b;

  // Operand mux: external user, squaring step, or multiply-by-z step.
  always_comb begin
    mul_a = acc;
    mul_b = z;
    if (ext_sel) begin
      mul_a = ext_a;
      mul_b = ext_b;
    end else if (sqr) begin
      mul_b = acc;
    end
  end

  mod_mul #(.LEN(LEN)) u_mul (
    .a        (mul_a),
    .b        (mul_b),
    .p        (p),
    .p_prime  (p_prime),
    .r2_mod_p (r2_mod_p),
    .y        (mul_y)
  );

  // done marks the cycle whose clock edge writes the final acc.
  assign done = busy && !sqr && (idx == '0);

  // Exponent loop: alternate square / conditional multiply, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      idx  <= '0;
      busy <= 1'b0;
      sqr  <= 1'b0;
    end else if (start) begin
      acc  <= LEN'(1);
      idx  <= IW'(LEN - 1);
      busy <= 1'b1;
      sqr  <= 1'b1;
    end else if (busy) begin
      if (sqr) begin
        acc <= mul_y;
        sqr <= 1'b0;
      end else begin
        if (e[idx]) acc <= mul_y;
        sqr <= 1'b1;
        if (idx == '0) busy <= 1'b0;
        else           idx  <= idx - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_mul.sv
// Combinational a*b mod p in the normal domain, built from two Montgomery
// reductions: redc(redc(a*b) * R^2) = a*b. Needs a, b < p and p odd, p < 2^LEN.
module mod_mul #(
  parameter int LEN = 256
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] p_prime,
  input  logic [LEN-1:0] r2_mod_p,
  output logic [LEN-1:0] y
);

  // Montgomery reduction: returns t * 2^-LEN mod p, fully reduced below p.
  function automatic logic [LEN-1:0] redc(input logic [2*LEN-1:0] t,
                                          input logic [LEN-1:0]   pm,
                                          input logic [LEN-1:0]   pp);
    logic [LEN-1:0]   m;
    logic [2*LEN:0]   mp;
    logic [2*LEN:0]   s;
    logic [LEN:0]     u;
    m  = t[LEN-1:0] * pp;
    mp = {{(LEN+1){1'b0}}, m} * {{(LEN+1){1'b0}}, pm};
    s  = {1'b0, t} + mp;
    u  = (LEN+1)'(s >> LEN);
    if (u >= {1'b0, pm}) u = u - {1'b0, pm};
    return u[LEN-1:0];
  endfunction

  logic [2*LEN-1:0] prod;
  logic [LEN-1:0]   mont;
  logic [2*LEN-1:0] lift;

  // Product, first reduction (lands in R^-1 domain), then lift back via R^2.
  always_comb begin
    prod = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
    mont = redc(prod, p, p_prime);
    lift = {{LEN{1'b0}}, mont} * {{LEN{1'b0}}, r2_mod_p};
    y    = redc(lift, p, p_prime);
  end

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) mod p. The inverse of Z comes
// from mod_inv_fermat; its multiplier is then borrowed for the four closing
// products. Z == 0 is the point at infinity and bypasses all arithmetic.
module jacobian_to_affine import ecc_pkg::*; #(
  parameter int LEN = ECC_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  jacobian_to_affine_if.slave  bus,
  output j2a_state_t           state
);

  logic [LEN-1:0] p_r, pp_r, r2_r, px_r, py_r, pz_r, e_r;
  logic [LEN-1:0] t2, t3, ax_r, ay_r;
  logic           inf_r, out_valid_r, in_ready_r;
  logic           accept, start, ext_sel, inv_done;
  logic [LEN-1:0] ext_a, ext_b, acc, mul_y;

  assign accept = bus.in_valid && in_ready_r;
  assign start  = accept && (bus.pz != '0);

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.ax        = ax_r;
  assign bus.ay        = ay_r;
  assign bus.inf       = inf_r;

  // Borrowed-multiplier operands for the closing products.
  always_comb begin
    ext_sel = 1'b0;
    ext_a   = '0;
    ext_b   = '0;
    unique case (state)
      Z2:   begin ext_sel = 1'b1; ext_a = acc;  ext_b = acc; end
      Z3:   begin ext_sel = 1'b1; ext_a = t2;   ext_b = acc; end
      OUTX: begin ext_sel = 1'b1; ext_a = px_r; ext_b = t2;  end
      OUTY: begin ext_sel = 1'b1; ext_a = py_r; ext_b = t3;  end
      default: ;
    endcase
  end

  mod_inv_fermat #(.LEN(LEN)) u_inv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .z        (pz_r),
    .e        (e_r),
    .p        (p_r),
    .p_prime  (pp_r),
    .r2_mod_p (r2_r),
    .ext_sel  (ext_sel),
    .ext_a    (ext_a),
    .ext_b    (ext_b),
    .acc      (acc),
    .mul_y    (mul_y),
    .done     (inv_done)
  );

  // Control FSM; EXP_SQR/EXP_MUL run in lockstep with the inversion loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      p_r  <= '0; pp_r <= '0; r2_r <= '0; e_r <= '0;
      px_r <= '0; py_r <= '0; pz_r <= '0;
      t2   <= '0; t3   <= '0;
      ax_r <= '0; ay_r <= '0; inf_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            p_r        <= bus.p;
            pp_r       <= bus.p_prime;
            r2_r       <= bus.r2_mod_p;
            e_r        <= bus.p - LEN'(2);
            px_r       <= bus.px;
            py_r       <= bus.py;
            pz_r       <= bus.pz;
            in_ready_r <= 1'b0;
            if (bus.pz == '0) begin
              ax_r        <= '0;
              ay_r        <= '0;
              inf_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              state <= EXP_SQR;
            end
          end
        end
        EXP_SQR: state <= EXP_MUL;
        EXP_MUL: state <= inv_done ? Z2 : EXP_SQR;
        Z2: begin
          t2    <= mul_y;
          state <= Z3;
        end
        Z3: begin
          t3    <= mul_y;
          state <= OUTX;
        end
        OUTX: begin
          ax_r  <= mul_y;
          state <= OUTY;
        end
        OUTY: begin
          ay_r        <= mul_y;
          inf_r       <= 1'b0;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed bench for jacobian_to_affine: small field (LEN=8, p=23) for the
// control scenarios, secp256k1 at LEN=256 for the full-width datapath.
module tb_jacobian_to_affine;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  j2a_state_t st8, st256;

  jacobian_to_affine_if #(.LEN(8))   b8 ();
  jacobian_to_affine_if #(.LEN(256)) b256 ();

  jacobian_to_affine #(.LEN(8)) u8 (
    .clk   (clk),
    .rst   (rst),
    .bus   (b8.slave),
    .state (st8)
  );

  jacobian_to_affine #(.LEN(256)) u256 (
    .clk   (clk),
    .rst   (rst),
    .bus   (b256.slave),
    .state (st256)
  );

  // Clock and global time guard.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a point on the 8-bit DUT and return just after the accept edge.
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    b8.px       = x;
    b8.py       = y;
    b8.pz       = z;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out8(output int lat);
    lat = 0;
    while (!b8.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_out256(output int lat);
    lat = 0;
    while (!b256.out_valid && lat < 700) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, m};
    return t[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    int           lat;
    logic [255:0] p256, pp256, r2_256, inv, xa, ya, za, zz, xj, yj;
    logic [512:0] big;

    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    b8.p = 8'd23; b8.p_prime = 8'd89; b8.r2_mod_p = 8'd9;
    b8.px = '0; b8.py = '0; b8.pz = '0;

    // secp256k1 field constants, derived independently of the design.
    p256 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    big  = 513'b1 << 512;
    big  = big % {257'b0, p256};
    r2_256 = big[255:0];
    inv = p256;
    for (int k = 0; k < 8; k++) inv = inv * (256'd2 - p256 * inv);
    pp256 = 256'd0 - inv;
    b256.in_valid = 1'b0; b256.out_ready = 1'b1;
    b256.p = p256; b256.p_prime = pp256; b256.r2_mod_p = r2_256;
    b256.px = '0; b256.py = '0; b256.pz = '0;

    // Reset values.
    repeat (3) tick();
    check("rst_in_ready",  256'(b8.in_ready), 256'(1));
    check("rst_out_valid", 256'(b8.out_valid), 256'(0));
    check("rst_ax",        256'(b8.ax), 256'(0));
    check("rst_ay",        256'(b8.ay), 256'(0));
    check("rst_inf",       256'(b8.inf), 256'(0));
    check("rst_state",     256'(st8), 256'(IDLE));
    check("rst256_in_ready", 256'(b256.in_ready), 256'(1));
    check("rst256_out_valid", 256'(b256.out_valid), 256'(0));
    rst = 1'b0;
    tick();

    // (12,11,2) -> (3,10): Z^2=4, Z^3=8, 8^-1=3 mod 23.
    check("t1_in_ready", 256'(b8.in_ready), 256'(1));
    send8(8'd12, 8'd11, 8'd2);
    check("t1_busy", 256'(b8.in_ready), 256'(0));
    wait_out8(lat);
    check("t1_latency", 256'(lat), 256'(20));
    check("t1_ax", 256'(b8.ax), 256'(3));
    check("t1_ay", 256'(b8.ay), 256'(10));
    check("t1_inf", 256'(b8.inf), 256'(0));
    tick();
    check("t1_release_in_ready", 256'(b8.in_ready), 256'(1));
    check("t1_release_out_valid", 256'(b8.out_valid), 256'(0));

    // Z = 1 passes coordinates through.
    send8(8'd3, 8'd10, 8'd1);
    wait_out8(lat);
    check("t2_latency", 256'(lat), 256'(20));
    check("t2_ax", 256'(b8.ax), 256'(3));
    check("t2_ay", 256'(b8.ay), 256'(10));
    check("t2_inf", 256'(b8.inf), 256'(0));
    tick();

    // Point at infinity: out_valid already up in the cycle after accept.
    send8(8'd5, 8'd7, 8'd0);
    wait_out8(lat);
    check("t3_latency", 256'(lat), 256'(0));
    check("t3_ax", 256'(b8.ax), 256'(0));
    check("t3_ay", 256'(b8.ay), 256'(0));
    check("t3_inf", 256'(b8.inf), 256'(1));
    tick();
    check("t3_in_ready", 256'(b8.in_ready), 256'(1));

    // Backpressure, with stray points offered while busy.
    b8.out_ready = 1'b0;
    send8(8'd12, 8'd11, 8'd2);
    repeat (3) tick();
    send8(8'd12, 8'd11, 8'd2);
    b8.px = 8'd5; b8.py = 8'd7; b8.pz = 8'd0;
    wait_out8(lat);
    check("t4_latency", 256'(lat), 256'(16));
    check("t4_ax", 256'(b8.ax), 256'(3));
    check("t4_ay", 256'(b8.ay), 256'(10));
    for (int k = 0; k < 10; k++) begin
      if (k == 4) send8(8'd5, 8'd7, 8'd0);
      else        tick();
      check("t4_hold_valid", 256'(b8.out_valid), 256'(1));
      check("t4_hold_in_ready", 256'(b8.in_ready), 256'(0));
      check("t4_hold_ax", 256'(b8.ax), 256'(3));
      check("t4_hold_ay", 256'(b8.ay), 256'(10));
      check("t4_hold_inf", 256'(b8.inf), 256'(0));
    end
    b8.out_ready = 1'b1;
    tick();
    check("t4_release_in_ready", 256'(b8.in_ready), 256'(1));
    check("t4_release_out_valid", 256'(b8.out_valid), 256'(0));
    repeat (3) tick();
    check("t4_no_ghost_valid", 256'(b8.out_valid), 256'(0));
    check("t4_no_ghost_state", 256'(st8), 256'(IDLE));

    // Reset seven clocks into a computation.
    send8(8'd12, 8'd11, 8'd2);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", 256'(b8.out_valid), 256'(0));
    check("t5_in_ready", 256'(b8.in_ready), 256'(1));
    check("t5_state", 256'(st8), 256'(IDLE));
    check("t5_ax_cleared", 256'(b8.ax), 256'(0));
    send8(8'd3, 8'd10, 8'd1);
    wait_out8(lat);
    check("t5_latency", 256'(lat), 256'(20));
    check("t5_ax", 256'(b8.ax), 256'(3));
    check("t5_ay", 256'(b8.ay), 256'(10));
    tick();

    // secp256k1: lift a random affine point with a random Z and recover it.
    for (int n = 0; n < 2; n++) begin
      xa = rand256() % p256;
      ya = rand256() % p256;
      za = rand256() % p256;
      if (za == '0) za = 256'd1;
      zz = mulmod(za, za, p256);
      xj = mulmod(xa, zz, p256);
      yj = mulmod(ya, mulmod(zz, za, p256), p256);
      check("t6_in_ready", 256'(b256.in_ready), 256'(1));
      b256.px = xj; b256.py = yj; b256.pz = za;
      b256.in_valid = 1'b1;
      tick();
      b256.in_valid = 1'b0;
      wait_out256(lat);
      check("t6_latency", 256'(lat), 256'(516));
      check("t6_ax", b256.ax, xa);
      check("t6_ay", b256.ay, ya);
      check("t6_inf", 256'(b256.inf), 256'(0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobian_to_affine.md
Name: jacobian_to_affine

Overview:
- Converts a Jacobian point (X, Y, Z), as produced by the doubling and addition datapaths, back to affine (x, y) = (X/Z^2, Y/Z^3) mod p.
- Sits at the output end of the scalar-multiply chain and undoes the affine-to-Jacobian lift done at its input.
- Computes Z^-1 by Fermat (Z^(p-2)) with square-and-multiply on a single shared mod_mul instance, under an FSM with valid/ready handshakes on both sides.

Parameters:
LEN, 256, field/operand width in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input point and field constants valid
in_ready  out  1  block can accept a point
p  in  LEN  field prime
p_prime  in  LEN  Montgomery constant -p^-1 mod 2^LEN
r2_mod_p  in  LEN  2^(2*LEN) mod p
px, py, pz  in  LEN each  Jacobian input coordinates, each < p
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
ax, ay  out  LEN each  affine result
inf  out  1  input was point at infinity (pz == 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, ax=0, ay=0, inf=0. All internal registers cleared.
- Reset mid-operation: abandon the computation. Next cycle the block is IDLE, out_valid=0 and in_ready=1.
- in_ready = (state == IDLE).
- Accept occurs when in_valid && in_ready. On accept, register p, p_prime, r2_mod_p, px, py, pz and e = p - 2.
- States: IDLE, EXP_SQR, EXP_MUL, Z2, Z3, OUTX, OUTY, DONE.
- IDLE, accept with pz==0: go to DONE with ax=0, ay=0, inf=1. out_valid is high 1 cycle after the accept edge.
- IDLE, accept with pz!=0: acc=1, bit index i=LEN-1, go to EXP_SQR.
- EXP_SQR: acc <= acc*acc, go to EXP_MUL.
- EXP_MUL: acc <= e[i] ? acc*pz : acc. This state is always spent, so latency is fixed. If i==0 go to Z2, else i <= i-1 and go to EXP_SQR.
- Z2: t2 <= acc*acc (zinv^2).
- Z3: t3 <= t2*acc (zinv^3).
- OUTX: ax <= px*t2.
- OUTY: ay <= py*t3, inf <= 0, go to DONE.
- DONE: out_valid=1. ax, ay and inf stay stable until out_valid && out_ready, then go to IDLE.
  - Held out_ready=0 holds DONE indefinitely.
  - A new point can be accepted at the earliest 1 cycle after the output handshake.
- Latency: out_valid is high exactly 2*LEN+4 clocks after the accept edge when pz!=0. For LEN=256 that is 516.
- Multiplier: one combinational mod_mul instance with muxed operands, yielding a*b mod p in the normal (non-Montgomery) domain. All register results are < p.
- Exponent: e = p - 2 is computed with plain LEN-bit subtraction. p is odd and > 3, so there is no wrap.
- in_valid while busy is ignored. Inputs are sampled only at accept; changing them afterwards has no effect.

Decomposition:
- Package ecc_pkg holds:
  - the state enum for this FSM (j2a_state_t);
  - the default LEN localparam, shared with point_double and point_add.
- One natural sub-module: mod_inv_fermat.
  - Owns the EXP_SQR/EXP_MUL loop, acc, the bit index, and the mod_mul instance.
  - Handshake: start/done, fixed 2*LEN cycles.
  - The top FSM reuses its multiplier through an operand mux for Z2..OUTY.
- Existing mod_mul and mod_sub modules are reused unchanged.

Test Plan:
- Bench configuration for all scenarios: LEN=8, p=23, p_prime=89, r2_mod_p=9.
- Identity Z: (12,11,2) -> ax=3, ay=10, inf=0. Curve y^2=x^3+x+1, affine (3,10). out_valid rises exactly 20 clocks after the accept edge.
- Z=1 identity: (3,10,1) -> ax=3, ay=10, out_valid after 20 clocks.
- Infinity: pz=0, px=5, py=7 -> ax=0, ay=0, inf=1, out_valid 1 clock after accept.
- Backpressure: out_ready low for 10 cycles after out_valid.
  - ax/ay/inf are stable and in_ready=0 throughout.
  - On release, in_ready=1 the next cycle.
  - A second point (12,11,2) pulsed during busy is ignored.
- Reset mid-op: assert rst at clock 7 after accept of (12,11,2) -> next cycle out_valid=0, in_ready=1. A fresh accept of (3,10,1) then yields (3,10).
- Random LEN=256 over secp256k1 p: random affine point and random Z, Jacobian formed by the reference model -> recovered affine matches, latency 516.
